// File: rtl/fw_interface_arb_pkg.sv
// Shared types and constants for the two-master firmware-interface Wishbone arbiter.
// Optional watchdog build: define FW_INTERFACE_ARB_TIMEOUT_EN.
package fw_interface_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'b00,
    ARB_GNT0 = 2'b01,
    ARB_GNT1 = 2'b10
  } arb_state_t;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M0   = 2'b01;
  localparam logic [1:0] GNT_M1   = 2'b10;

  localparam int FW_ARB_TIMEOUT_MAX = 65535;

  function automatic logic [1:0] state_to_gnt(input arb_state_t st);
    logic [1:0] gnt;
    gnt = GNT_NONE;
    case (st)
      ARB_GNT0: gnt = GNT_M0;
      ARB_GNT1: gnt = GNT_M1;
      default:  gnt = GNT_NONE;
    endcase
    return gnt;
  endfunction

endpackage

// File: rtl/fw_interface_arb_wdog.sv
// Stall watchdog for the arbiter: counts unanswered strobe cycles and flags the
// cycle in which the count reaches TIMEOUT. Built only with FW_INTERFACE_ARB_TIMEOUT_EN.
module fw_interface_arb_wdog
  import fw_interface_arb_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic wb_clk_i,
  input  logic wb_rst_n_i,
  input  logic stb,
  input  logic ack,
  input  logic err,
  input  logic gnt_chg,
  output logic hit
);

  localparam int TMO_EFF = (TIMEOUT > FW_ARB_TIMEOUT_MAX) ? FW_ARB_TIMEOUT_MAX :
                           ((TIMEOUT < 1) ? 1 : TIMEOUT);
  localparam int CW = $clog2(TMO_EFF + 1);
  localparam logic [CW-1:0] CNT_TMO = CW'(TMO_EFF);
  localparam logic [CW-1:0] CNT_MAX = '1;

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  assign hit = (cnt == CNT_TMO);

  always_comb begin
    cnt_nxt = cnt;
    if (hit || !stb || ack || err || gnt_chg) begin
      cnt_nxt = '0;
    end else if (cnt != CNT_MAX) begin
      cnt_nxt = cnt + CW'(1);
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/fw_interface_arb.sv
// Two-master Wishbone arbiter in front of the firmware-test interface slave; a master
// keeps the bus for its whole cyc. Optional watchdog: define FW_INTERFACE_ARB_TIMEOUT_EN.
//
//   state    | meaning
//   ARB_IDLE | no owner, all slave outputs 0
//   ARB_GNT0 | m0 (CPU data bus) owns the slave
//   ARB_GNT1 | m1 (testbench/debug master) owns the slave
module fw_interface_arb
  import fw_interface_arb_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,

  input  logic [31:0] m0_wb_adr_i,
  input  logic [31:0] m0_wb_dat_i,
  input  logic [3:0]  m0_wb_sel_i,
  input  logic        m0_wb_we_i,
  input  logic [1:0]  m0_wb_bte_i,
  input  logic [2:0]  m0_wb_cti_i,
  input  logic        m0_wb_cyc_i,
  input  logic        m0_wb_stb_i,
  output logic        m0_wb_ack_o,
  output logic        m0_wb_err_o,
  output logic [31:0] m0_wb_dat_o,

  input  logic [31:0] m1_wb_adr_i,
  input  logic [31:0] m1_wb_dat_i,
  input  logic [3:0]  m1_wb_sel_i,
  input  logic        m1_wb_we_i,
  input  logic [1:0]  m1_wb_bte_i,
  input  logic [2:0]  m1_wb_cti_i,
  input  logic        m1_wb_cyc_i,
  input  logic        m1_wb_stb_i,
  output logic        m1_wb_ack_o,
  output logic        m1_wb_err_o,
  output logic [31:0] m1_wb_dat_o,

  output logic [31:0] s_wb_adr_o,
  output logic [31:0] s_wb_dat_o,
  output logic [3:0]  s_wb_sel_o,
  output logic        s_wb_we_o,
  output logic [1:0]  s_wb_bte_o,
  output logic [2:0]  s_wb_cti_o,
  output logic        s_wb_cyc_o,
  output logic        s_wb_stb_o,
  input  logic        s_wb_ack_i,
  input  logic        s_wb_err_i,
  input  logic [31:0] s_wb_dat_i,

  output logic [1:0]  gnt_o
);

  arb_state_t state;
  arb_state_t state_nxt;
  logic       last_m1;
  logic       last_m1_nxt;
  logic       owner_hold;
  logic       sel0;
  logic       sel1;
  logic       owner_stb;
  logic       tmo_hit;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state   <= ARB_IDLE;
      last_m1 <= 1'b1;
    end else begin
      state   <= state_nxt;
      last_m1 <= last_m1_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    last_m1_nxt = last_m1;
    owner_hold  = ((state == ARB_GNT0) && m0_wb_cyc_i) ||
                  ((state == ARB_GNT1) && m1_wb_cyc_i);
    if (!owner_hold) begin
      if (m0_wb_cyc_i && m1_wb_cyc_i) begin
        state_nxt = last_m1 ? ARB_GNT0 : ARB_GNT1;
      end else if (m0_wb_cyc_i) begin
        state_nxt = ARB_GNT0;
      end else if (m1_wb_cyc_i) begin
        state_nxt = ARB_GNT1;
      end else begin
        state_nxt = ARB_IDLE;
      end
    end
    case (state_nxt)
      ARB_GNT0: last_m1_nxt = 1'b0;
      ARB_GNT1: last_m1_nxt = 1'b1;
      default:  last_m1_nxt = last_m1;
    endcase
  end

  assign gnt_o = state_to_gnt(state);
  assign sel0  = (state == ARB_GNT0);
  assign sel1  = (state == ARB_GNT1);

  // AND-OR mux: with no owner every slave-side signal collapses to 0.
  always_comb begin
    s_wb_adr_o = ({32{sel0}} & m0_wb_adr_i) | ({32{sel1}} & m1_wb_adr_i);
    s_wb_dat_o = ({32{sel0}} & m0_wb_dat_i) | ({32{sel1}} & m1_wb_dat_i);
    s_wb_sel_o = ({4{sel0}}  & m0_wb_sel_i) | ({4{sel1}}  & m1_wb_sel_i);
    s_wb_we_o  = (sel0 & m0_wb_we_i)  | (sel1 & m1_wb_we_i);
    s_wb_bte_o = ({2{sel0}}  & m0_wb_bte_i) | ({2{sel1}}  & m1_wb_bte_i);
    s_wb_cti_o = ({3{sel0}}  & m0_wb_cti_i) | ({3{sel1}}  & m1_wb_cti_i);
    s_wb_cyc_o = (sel0 & m0_wb_cyc_i) | (sel1 & m1_wb_cyc_i);
    owner_stb  = (sel0 & m0_wb_stb_i) | (sel1 & m1_wb_stb_i);
    s_wb_stb_o = owner_stb & ~tmo_hit;
  end

  always_comb begin
    m0_wb_ack_o = sel0 & s_wb_ack_i;
    m0_wb_err_o = sel0 & (s_wb_err_i | tmo_hit);
    m0_wb_dat_o = {32{sel0}} & s_wb_dat_i;
    m1_wb_ack_o = sel1 & s_wb_ack_i;
    m1_wb_err_o = sel1 & (s_wb_err_i | tmo_hit);
    m1_wb_dat_o = {32{sel1}} & s_wb_dat_i;
  end

`ifdef FW_INTERFACE_ARB_TIMEOUT_EN
  // The watchdog sees the unforced strobe so the forced-low cycle is not itself a reset cause.
  fw_interface_arb_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_n_i (wb_rst_n_i),
    .stb        (owner_stb),
    .ack        (s_wb_ack_i),
    .err        (s_wb_err_i),
    .gnt_chg    (state_nxt != state),
    .hit        (tmo_hit)
  );
`else
  localparam int unused_timeout = TIMEOUT;
  assign tmo_hit = 1'b0;
`endif

endmodule

// File: tb/tb_fw_interface_arb.sv
// Self-checking bench for fw_interface_arb: directed scenarios plus randomized traffic
// against a cycle-level ownership model. Watchdog scenario needs FW_INTERFACE_ARB_TIMEOUT_EN.
module tb_fw_interface_arb;

  localparam int TB_TIMEOUT = 4;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_n_i;
  logic [31:0] m0_wb_adr_i, m0_wb_dat_i, m1_wb_adr_i, m1_wb_dat_i;
  logic [3:0]  m0_wb_sel_i, m1_wb_sel_i;
  logic        m0_wb_we_i, m1_wb_we_i;
  logic [1:0]  m0_wb_bte_i, m1_wb_bte_i;
  logic [2:0]  m0_wb_cti_i, m1_wb_cti_i;
  logic        m0_wb_cyc_i, m0_wb_stb_i, m1_wb_cyc_i, m1_wb_stb_i;
  logic        m0_wb_ack_o, m0_wb_err_o, m1_wb_ack_o, m1_wb_err_o;
  logic [31:0] m0_wb_dat_o, m1_wb_dat_o;
  logic [31:0] s_wb_adr_o, s_wb_dat_o;
  logic [3:0]  s_wb_sel_o;
  logic        s_wb_we_o;
  logic [1:0]  s_wb_bte_o;
  logic [2:0]  s_wb_cti_o;
  logic        s_wb_cyc_o, s_wb_stb_o;
  logic        s_wb_ack_i, s_wb_err_i;
  logic [31:0] s_wb_dat_i;
  logic [1:0]  gnt_o;

  // Slave stand-in: either acks combinationally on stb, or follows bench-driven values.
  logic slv_auto;
  logic slv_ack;
  assign s_wb_ack_i = slv_auto ? s_wb_stb_o : slv_ack;

  int n_checks = 0;
  int n_err    = 0;
  int mg       = 0;   // model owner: 0 none, 1 m0, 2 m1
  int mlast    = 1;   // model last owner index
  logic saw_err;

  fw_interface_arb #(.TIMEOUT(TB_TIMEOUT)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_n_i(wb_rst_n_i),
    .m0_wb_adr_i(m0_wb_adr_i), .m0_wb_dat_i(m0_wb_dat_i), .m0_wb_sel_i(m0_wb_sel_i),
    .m0_wb_we_i(m0_wb_we_i), .m0_wb_bte_i(m0_wb_bte_i), .m0_wb_cti_i(m0_wb_cti_i),
    .m0_wb_cyc_i(m0_wb_cyc_i), .m0_wb_stb_i(m0_wb_stb_i),
    .m0_wb_ack_o(m0_wb_ack_o), .m0_wb_err_o(m0_wb_err_o), .m0_wb_dat_o(m0_wb_dat_o),
    .m1_wb_adr_i(m1_wb_adr_i), .m1_wb_dat_i(m1_wb_dat_i), .m1_wb_sel_i(m1_wb_sel_i),
    .m1_wb_we_i(m1_wb_we_i), .m1_wb_bte_i(m1_wb_bte_i), .m1_wb_cti_i(m1_wb_cti_i),
    .m1_wb_cyc_i(m1_wb_cyc_i), .m1_wb_stb_i(m1_wb_stb_i),
    .m1_wb_ack_o(m1_wb_ack_o), .m1_wb_err_o(m1_wb_err_o), .m1_wb_dat_o(m1_wb_dat_o),
    .s_wb_adr_o(s_wb_adr_o), .s_wb_dat_o(s_wb_dat_o), .s_wb_sel_o(s_wb_sel_o),
    .s_wb_we_o(s_wb_we_o), .s_wb_bte_o(s_wb_bte_o), .s_wb_cti_o(s_wb_cti_o),
    .s_wb_cyc_o(s_wb_cyc_o), .s_wb_stb_o(s_wb_stb_o),
    .s_wb_ack_i(s_wb_ack_i), .s_wb_err_i(s_wb_err_i), .s_wb_dat_i(s_wb_dat_i),
    .gnt_o(gnt_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Ownership rules at a clock edge: the owner keeps the bus while its cyc is high;
  // otherwise a lone requester wins, a tie goes to whoever did not own last.
  task automatic model_edge();
    bit keep;
    keep = (mg == 1 && m0_wb_cyc_i) || (mg == 2 && m1_wb_cyc_i);
    if (!keep) begin
      if (m0_wb_cyc_i && m1_wb_cyc_i) mg = (mlast == 1) ? 1 : 2;
      else if (m0_wb_cyc_i)           mg = 1;
      else if (m1_wb_cyc_i)           mg = 2;
      else                            mg = 0;
      if (mg != 0) mlast = mg - 1;
    end
  endtask

  // Compare every output against the model for the current cycle, then advance the model.
  task automatic chk_all();
    logic [31:0] e_adr, e_dat;
    logic [3:0]  e_sel;
    logic [1:0]  e_bte, e_gnt;
    logic [2:0]  e_cti;
    logic        e_we, e_cyc, e_stb, e_ack;
    #1;
    {e_adr, e_dat, e_sel, e_bte, e_cti, e_we, e_cyc, e_stb} = '0;
    e_gnt = 2'b00;
    if (mg == 1) begin
      e_gnt = 2'b01; e_adr = m0_wb_adr_i; e_dat = m0_wb_dat_i; e_sel = m0_wb_sel_i;
      e_bte = m0_wb_bte_i; e_cti = m0_wb_cti_i; e_we = m0_wb_we_i;
      e_cyc = m0_wb_cyc_i; e_stb = m0_wb_stb_i;
    end else if (mg == 2) begin
      e_gnt = 2'b10; e_adr = m1_wb_adr_i; e_dat = m1_wb_dat_i; e_sel = m1_wb_sel_i;
      e_bte = m1_wb_bte_i; e_cti = m1_wb_cti_i; e_we = m1_wb_we_i;
      e_cyc = m1_wb_cyc_i; e_stb = m1_wb_stb_i;
    end
    e_ack = slv_auto ? e_stb : slv_ack;
    chk("gnt",    gnt_o,      e_gnt);
    chk("s_adr",  s_wb_adr_o, e_adr);
    chk("s_dat",  s_wb_dat_o, e_dat);
    chk("s_sel",  s_wb_sel_o, e_sel);
    chk("s_we",   s_wb_we_o,  e_we);
    chk("s_bte",  s_wb_bte_o, e_bte);
    chk("s_cti",  s_wb_cti_o, e_cti);
    chk("s_cyc",  s_wb_cyc_o, e_cyc);
    chk("s_stb",  s_wb_stb_o, e_stb);
    chk("m0_ack", m0_wb_ack_o, (mg == 1) ? e_ack : 1'b0);
    chk("m0_err", m0_wb_err_o, (mg == 1) ? s_wb_err_i : 1'b0);
    chk("m0_dat", m0_wb_dat_o, (mg == 1) ? s_wb_dat_i : 32'h0);
    chk("m1_ack", m1_wb_ack_o, (mg == 2) ? e_ack : 1'b0);
    chk("m1_err", m1_wb_err_o, (mg == 2) ? s_wb_err_i : 1'b0);
    chk("m1_dat", m1_wb_dat_o, (mg == 2) ? s_wb_dat_i : 32'h0);
    model_edge();
  endtask

  task automatic drive(input logic c0, input logic s0, input logic c1, input logic s1);
    @(negedge wb_clk_i);
    m0_wb_cyc_i = c0; m0_wb_stb_i = s0;
    m1_wb_cyc_i = c1; m1_wb_stb_i = s1;
    chk_all();
  endtask

  task automatic do_reset();
    wb_rst_n_i = 1'b0;
    {m0_wb_adr_i, m0_wb_dat_i, m0_wb_sel_i, m0_wb_we_i, m0_wb_bte_i, m0_wb_cti_i} = '0;
    {m1_wb_adr_i, m1_wb_dat_i, m1_wb_sel_i, m1_wb_we_i, m1_wb_bte_i, m1_wb_cti_i} = '0;
    {m0_wb_cyc_i, m0_wb_stb_i, m1_wb_cyc_i, m1_wb_stb_i} = '0;
    slv_auto = 1'b1; slv_ack = 1'b0; s_wb_err_i = 1'b0; s_wb_dat_i = 32'h0;
    mg = 0; mlast = 1;
    repeat (2) @(negedge wb_clk_i);
    wb_rst_n_i = 1'b1;
    #1;
    chk("reset_gnt", gnt_o, 2'b00);
    chk("reset_s_cyc", s_wb_cyc_o, 1'b0);
  endtask

  initial begin
    // Single write from m0.
    do_reset();
    m0_wb_adr_i = 32'h4; m0_wb_dat_i = 32'hDEAD_BEEF; m0_wb_sel_i = 4'hF; m0_wb_we_i = 1'b1;
    s_wb_dat_i = 32'h1234_5678;
    drive(1, 1, 0, 0);
    chk("single_req_gnt", gnt_o, 2'b00);
    drive(1, 1, 0, 0);
    chk("single_gnt", gnt_o, 2'b01);
    chk("single_adr", s_wb_adr_o, 32'h4);
    chk("single_dat", s_wb_dat_o, 32'hDEAD_BEEF);
    chk("single_m0_ack", m0_wb_ack_o, 1'b1);
    chk("single_m1_ack", m1_wb_ack_o, 1'b0);
    drive(0, 0, 0, 0);

    // Tie after reset, handover, then rotation back to m0.
    do_reset();
    drive(1, 1, 1, 1);
    drive(1, 1, 1, 1);
    chk("tie_first", gnt_o, 2'b01);
    drive(0, 0, 1, 1);
    chk("tie_hold_until_edge", gnt_o, 2'b01);
    drive(0, 0, 1, 1);
    chk("handover_m1", gnt_o, 2'b10);
    drive(0, 0, 0, 0);
    drive(1, 1, 1, 1);
    chk("idle_between", gnt_o, 2'b00);
    drive(1, 1, 1, 1);
    chk("rotate_m0", gnt_o, 2'b01);

    // No preemption during an m0 burst.
    do_reset();
    m1_wb_adr_i = 32'h99; m0_wb_adr_i = 32'h11;
    drive(1, 1, 0, 0);
    for (int b = 0; b < 3; b++) begin
      m0_wb_adr_i = 32'h11 + b;
      drive(1, 1, 1, 1);
      chk("burst_gnt", gnt_o, 2'b01);
      chk("burst_adr", s_wb_adr_o, 32'h11 + b);
    end
    drive(0, 0, 1, 1);
    chk("burst_release_gnt", gnt_o, 2'b01);
    drive(0, 0, 1, 1);
    chk("burst_m1_gnt", gnt_o, 2'b10);
    chk("burst_m1_adr", s_wb_adr_o, 32'h99);

`ifdef FW_INTERFACE_ARB_TIMEOUT_EN
    // Watchdog: slave silent, err expected in the fifth strobe cycle.
    do_reset();
    slv_auto = 1'b0; slv_ack = 1'b0; s_wb_err_i = 1'b0;
    drive(1, 1, 0, 0);
    for (int i = 1; i <= 6; i++) begin
      @(negedge wb_clk_i);
      #1;
      chk("tmo_gnt", gnt_o, 2'b01);
      chk("tmo_err", m0_wb_err_o, (i == 5) ? 1'b1 : 1'b0);
      chk("tmo_stb", s_wb_stb_o, (i == 5) ? 1'b0 : 1'b1);
    end
`else
    // Slave error routing and no self-generated error without the watchdog.
    do_reset();
    slv_auto = 1'b0; slv_ack = 1'b0;
    drive(0, 0, 1, 1);
    s_wb_err_i = 1'b1;
    drive(0, 0, 1, 1);
    chk("m1_err_pass", m1_wb_err_o, 1'b1);
    s_wb_err_i = 1'b0;
    saw_err = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      drive(0, 0, 1, 1);
      saw_err = saw_err | m1_wb_err_o;
    end
    chk("no_err_1000", saw_err, 1'b0);
`endif

    // Asynchronous reset during an m1 access.
    do_reset();
    drive(0, 0, 1, 1);
    drive(0, 0, 1, 1);
    chk("pre_rst_gnt", gnt_o, 2'b10);
    #2;
    wb_rst_n_i = 1'b0;
    #1;
    chk("rst_gnt", gnt_o, 2'b00);
    chk("rst_s_adr", s_wb_adr_o, 32'h0);
    chk("rst_any_out", |{s_wb_dat_o, s_wb_sel_o, s_wb_we_o, s_wb_bte_o, s_wb_cti_o,
                        s_wb_cyc_o, s_wb_stb_o, m0_wb_ack_o, m0_wb_err_o, m0_wb_dat_o,
                        m1_wb_ack_o, m1_wb_err_o, m1_wb_dat_o}, 1'b0);
    mg = 0; mlast = 1;
    m0_wb_cyc_i = 1'b1; m0_wb_stb_i = 1'b1;
    @(negedge wb_clk_i);
    wb_rst_n_i = 1'b1;
    chk_all();
    drive(1, 1, 1, 1);
    chk("post_rst_m0", gnt_o, 2'b01);

    // Randomized traffic; slave always answers so the watchdog stays quiet.
    do_reset();
    slv_auto = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge wb_clk_i);
      if ($urandom_range(3) == 0) m0_wb_cyc_i = ~m0_wb_cyc_i;
      if ($urandom_range(3) == 0) m1_wb_cyc_i = ~m1_wb_cyc_i;
      m0_wb_stb_i = m0_wb_cyc_i && ($urandom_range(1) == 1);
      m1_wb_stb_i = m1_wb_cyc_i && ($urandom_range(1) == 1);
      m0_wb_adr_i = $urandom; m0_wb_dat_i = $urandom; m0_wb_sel_i = 4'($urandom);
      m1_wb_adr_i = $urandom; m1_wb_dat_i = $urandom; m1_wb_sel_i = 4'($urandom);
      m0_wb_we_i  = 1'($urandom); m1_wb_we_i = 1'($urandom);
      m0_wb_bte_i = 2'($urandom); m1_wb_bte_i = 2'($urandom);
      m0_wb_cti_i = 3'($urandom); m1_wb_cti_i = 3'($urandom);
      slv_ack     = 1'($urandom);
      s_wb_err_i  = ~slv_ack;
      s_wb_dat_i  = $urandom;
      chk_all();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
